fp_mul_issue_ctrl: RTL and testbench

FP_MUL_ISSUE_CTRL -- requirements
Module: fp_mul_issue_ctrl

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_special_detect.sv | 55 +++++
 rtl/fp_mul_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_fp_mul_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and the issue-controller state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [31:0]      POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_special_detect.sv
// Classifies an operand pair and builds the bypass result for special cases.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the outputs.
module fp_special_detect
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] byp_result,
    output logic        byp_exception,
    output logic        byp_overflow,
    output logic        byp_underflow
);

    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] man_a, man_b;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, den_a, den_b;
    logic              sign_r;

    assign exp_a  = a[EXP_W+MANT_W-1:MANT_W];
    assign exp_b  = b[EXP_W+MANT_W-1:MANT_W];
    assign man_a  = a[MANT_W-1:0];
    assign man_b  = b[MANT_W-1:0];
    assign nan_a  = (exp_a == EXP_MAX) && (man_a != '0);
    assign nan_b  = (exp_b == EXP_MAX) && (man_b != '0);
    assign inf_a  = (exp_a == EXP_MAX) && (man_a == '0);
    assign inf_b  = (exp_b == EXP_MAX) && (man_b == '0);
    assign zero_a = (exp_a == '0) && (man_a == '0);
    assign zero_b = (exp_b == '0) && (man_b == '0);
    assign den_a  = (exp_a == '0) && (man_a != '0);
    assign den_b  = (exp_b == '0) && (man_b != '0);
    assign sign_r = a[31] ^ b[31];

    // Priority NaN > inf > denormal > zero; denormals flush to a signed zero.
    always_comb begin
        is_special    = 1'b1;
        byp_result    = {sign_r, 31'd0};
        byp_exception = 1'b0;
        byp_overflow  = 1'b0;
        byp_underflow = 1'b0;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            byp_result    = QNAN;
            byp_exception = 1'b1;
        end else if (inf_a || inf_b) begin
            byp_result    = POS_INF | {sign_r, 31'd0};
            byp_overflow  = 1'b1;
        end else if (den_a || den_b) begin
            byp_underflow = 1'b1;
        end else if (!(zero_a || zero_b)) begin
            is_special    = 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Issues operand pairs to an external multi-cycle float multiplier, bypassing special values.
// Latency: accept cycle N -> out_valid in cycle N+LATENCY+2 (multiplier) or N+1 (bypass).
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
module fp_mul_issue_ctrl
    import fp_pkg::*;
#(
    parameter int LATENCY = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    input  logic [31:0] mul_result,
    input  logic        mul_exception,
    input  logic        mul_overflow,
    input  logic        mul_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_exception,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic [2:0]  sticky_flags,
    input  logic        clr_sticky
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_special;
    logic [31:0]        byp_result;
    logic               byp_exception, byp_overflow, byp_underflow;
    logic               out_xfer;

    fp_special_detect u_detect (
        .a             (in_a),
        .b             (in_b),
        .is_special    (is_special),
        .byp_result    (byp_result),
        .byp_exception (byp_exception),
        .byp_overflow  (byp_overflow),
        .byp_underflow (byp_underflow)
    );

    assign out_xfer = out_valid && out_ready;

    // Issue FSM; every handshake and multiplier-facing output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            in_ready      <= 1'b1;
            mul_start     <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_exception <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        in_ready <= 1'b0;
                        if (is_special) begin
                            out_result    <= byp_result;
                            out_exception <= byp_exception;
                            out_overflow  <= byp_overflow;
                            out_underflow <= byp_underflow;
                            out_valid     <= 1'b1;
                            state         <= S_HOLD;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    mul_start <= 1'b0;
                    cnt       <= CNT_W'(LATENCY - 1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // The multiplier output is only trusted on the cnt==0 cycle.
                    if (cnt == '0) begin
                        out_result    <= mul_result;
                        out_exception <= mul_exception;
                        out_overflow  <= mul_overflow;
                        out_underflow <= mul_underflow;
                        out_valid     <= 1'b1;
                        state         <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a clear drops old bits, flags from a same-cycle transfer still set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (clr_sticky ? 3'b000 : sticky_flags)
                          | (out_xfer ? {out_exception, out_overflow, out_underflow} : 3'b000);
        end
    end

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Randomised and directed bench for fp_mul_issue_ctrl with a fixed-latency multiplier model.
// Latency: checks exact out_valid timing for both multiplier and bypass paths.
// Backpressure: holds out_ready low for random stretches and checks outputs stay frozen.
module tb_fp_mul_issue_ctrl;

    localparam int LATENCY = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [31:0] mul_a, mul_b;
    logic        mul_start;
    logic [31:0] mul_result;
    logic        mul_exception, mul_overflow, mul_underflow;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_exception, out_overflow, out_underflow;
    logic [2:0]  sticky_flags;
    logic        clr_sticky = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  exp_sticky = 3'b000;

    always #5 clk = ~clk;

    fp_mul_issue_ctrl #(.LATENCY(LATENCY)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_start     (mul_start),
        .mul_result    (mul_result),
        .mul_exception (mul_exception),
        .mul_overflow  (mul_overflow),
        .mul_underflow (mul_underflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_exception (out_exception),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .sticky_flags  (sticky_flags),
        .clr_sticky    (clr_sticky)
    );

    // Stand-in multiplier: {flags, result}; known product for 3.3*3.6, a hash otherwise.
    function automatic logic [34:0] mdl_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] h;
        if (a == 32'h40533333 && b == 32'h40666666) return {3'b000, 32'h413E147B};
        h = (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]};
        return {h[2:0] ^ h[10:8], h};
    endfunction

    // Multiplier model: result is valid only LATENCY cycles after the start pulse ends.
    logic [31:0] mdl_a = '0, mdl_b = '0;
    int          mdl_k = 1000;
    logic [34:0] mdl_good;
    always @(posedge clk) begin
        if (mul_start) begin
            mdl_a <= mul_a;
            mdl_b <= mul_b;
            mdl_k <= 0;
        end else if (mdl_k < 1000) begin
            mdl_k <= mdl_k + 1;
        end
    end
    assign mdl_good = mdl_mul(mdl_a, mdl_b);
    assign {mul_exception, mul_overflow, mul_underflow, mul_result} =
        (mdl_k == LATENCY - 1) ? mdl_good : ~mdl_good;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outcome from the IEEE special-value rules; byp=1 means no multiplier use.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [2:0] f, output bit byp);
        int ea, eb, ma, mb;
        bit na, nb, ia, ib, za, zb, da, db, sg;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = int'(a[22:0]);  mb = int'(b[22:0]);
        na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
        ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
        za = (ea == 0) && (ma == 0);   zb = (eb == 0) && (mb == 0);
        da = (ea == 0) && (ma != 0);   db = (eb == 0) && (mb != 0);
        sg = a[31] ^ b[31];
        byp = 1'b1;
        if (na || nb || (ia && zb) || (ib && za)) begin r = 32'h7FC00000;       f = 3'b100; end
        else if (ia || ib)                        begin r = {sg, 8'hFF, 23'd0}; f = 3'b010; end
        else if (da || db)                        begin r = {sg, 31'd0};        f = 3'b001; end
        else if (za || zb)                        begin r = {sg, 31'd0};        f = 3'b000; end
        else begin
            byp = 1'b0;
            {f, r} = mdl_mul(a, b);
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] m;
        logic        s;
        m = $urandom;
        s = m[31];
        case ($urandom_range(0, 7))
            0:       return {s, 31'd0};
            1:       return {s, 8'h00, (m[22:0] == 23'd0) ? 23'd1 : m[22:0]};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, (m[22:0] == 23'd0) ? 23'd5 : m[22:0]};
            default: return {s, 8'($urandom_range(1, 254)), m[22:0]};
        endcase
    endfunction

    // One complete operation: issue, time the result, hold under backpressure, drain.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit clr, input int hold);
        logic [31:0] e_res;
        logic [2:0]  e_flg;
        bit          e_byp;
        int          t, lat, starts;
        ref_op(a, b, e_res, e_flg, e_byp);
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        lat = 0; starts = 0;
        while (!out_valid && lat < 200) begin
            starts += int'(mul_start);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e_byp ? 0 : LATENCY + 1);
        check("start_pulses", starts, e_byp ? 0 : 1);
        check("result", out_result, e_res);
        check("flags", {29'd0, out_exception, out_overflow, out_underflow}, {29'd0, e_flg});
        check("busy_not_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", out_result, e_res);
            check("hold_not_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; clr_sticky = clr;
        @(negedge clk);
        out_ready = 1'b0; clr_sticky = 1'b0;
        exp_sticky = (clr ? 3'b000 : exp_sticky) | e_flg;
        check("sticky", {29'd0, sticky_flags}, {29'd0, exp_sticky});
        check("drained", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int ghost;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_sticky", {29'd0, sticky_flags}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // First op lands on the first edge after reset release.
        run_op(32'h40533333, 32'h40666666, 1'b0, 0);
        check("product_3p3x3p6", out_result, 32'h413E147B);
        run_op(32'hC1233333, 32'h00000000, 1'b0, 0);
        check("neg_zero", out_result, 32'h80000000);
        run_op(32'h7F800000, 32'h00000000, 1'b0, 0);
        run_op(32'hFF800000, 32'h40000000, 1'b0, 0);
        check("sticky_110", {29'd0, sticky_flags}, 32'd6);
        run_op(32'hC1233333, 32'h00000000, 1'b0, 5);
        run_op(32'h00000001, 32'h40000000, 1'b1, 0);
        check("sticky_clr_001", {29'd0, sticky_flags}, 32'd1);
        run_op(32'h40533333, 32'h40666666, 1'b0, 2);

        // Reset in the middle of WAIT (cnt==8) discards the operation.
        @(negedge clk);
        in_a = 32'h40533333; in_b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_sticky = 3'b000;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_mul_start", {31'd0, mul_start}, 32'd0);
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_mul_b", mul_b, 32'd0);
        check("midrst_result", out_result, 32'd0);
        check("midrst_flags", {29'd0, out_exception, out_overflow, out_underflow}, 32'd0);
        check("midrst_sticky", {29'd0, sticky_flags}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ghost = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || mul_start) ghost++;
        end
        check("no_ghost_output", ghost, 0);
        check("idle_after_reset", {31'd0, in_ready}, 32'd1);

        for (int n = 0; n < 40; n++) begin
            run_op(rand_operand(), rand_operand(), ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
